// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw button level, flags every synchronized change,
// and qualifies a new level only after it has stayed stable for STABLE_CYCLES clocks.
module button_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic sig_sync,
    output logic sig_change,
    output logic db_sig,
    output logic db_rise,
    output logic db_fall
);
    logic             sync1_q, sync2_q, sync3_q, db_q, rise_q, fall_q;
    logic             sync1_d, sync2_d, sync3_d, db_d, rise_d, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold, done;
    always_comb begin
        sync1_d = button_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        hold    = (sync2_q ^ sync3_q) || (sync2_q == db_q);
        done    = cnt_q == CNT_W'(STABLE_CYCLES - 1);
        cnt_d   = (hold || done) ? '0 : cnt_q + 1'b1;
        db_d    = (!hold && done) ? sync2_q : db_q;
        rise_d  = !hold && done && sync2_q;
        fall_d  = !hold && done && !sync2_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign sig_sync   = sync2_q;
    assign sig_change = sync2_q ^ sync3_q;
    assign db_sig     = db_q;
    assign db_rise    = rise_q;
    assign db_fall    = fall_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: random and directed stimulus on a default and a STABLE_CYCLES=2 debouncer,
// checked each cycle against a run-length model plus literal latency/pulse expectations.
module tb_button_debouncer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button_in = 1'b0;
    logic ss1, sc1, db1, r1, f1;
    logic ss2, sc2, db2, r2, f2;
    int   errs = 0;
    int   checks = 0;
    bit   armed = 0;
    int   n_sc, n_r1, n_f1, n_db1, n_r2;

    always #5 clk = ~clk;

    button_debouncer dut1 (
        .clk(clk), .reset(reset), .button_in(button_in),
        .sig_sync(ss1), .sig_change(sc1), .db_sig(db1), .db_rise(r1), .db_fall(f1)
    );
    button_debouncer #(.STABLE_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .button_in(button_in),
        .sig_sync(ss2), .sig_change(sc2), .db_sig(db2), .db_rise(r2), .db_fall(f2)
    );

    // h[0] newest input sample, h[1] level seen two edges late, h[2] the one before it;
    // run = how many consecutive edges h[1] has held its present value.
    typedef struct {
        logic [2:0] h;
        int         run;
        logic       db, rise, fall;
    } mst_t;

    mst_t m1, m2;

    function automatic mst_t step(mst_t m, logic r, logic b, int s);
        mst_t n = m;
        if (r) begin
            n.h = '0; n.run = 0; n.db = 1'b0; n.rise = 1'b0; n.fall = 1'b0;
            return n;
        end
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (m.h[1] != m.db && m.run >= s + 1) begin
            n.db   = m.h[1];
            n.rise = m.h[1];
            n.fall = !m.h[1];
        end
        n.h   = {m.h[1:0], b};
        n.run = (n.h[1] == m.h[1]) ? ((m.run < 1000000) ? m.run + 1 : m.run) : 1;
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m1 = step(m1, reset, button_in, 16);
        m2 = step(m2, reset, button_in, 2);
        if (reset) armed = 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("sig_sync16", ss1, m1.h[1]);
            chk("sig_change16", sc1, m1.h[1] ^ m1.h[2]);
            chk("db_sig16", db1, m1.db);
            chk("db_rise16", r1, m1.rise);
            chk("db_fall16", f1, m1.fall);
            chk("sig_sync2", ss2, m2.h[1]);
            chk("sig_change2", sc2, m2.h[1] ^ m2.h[2]);
            chk("db_sig2", db2, m2.db);
            chk("db_rise2", r2, m2.rise);
            chk("db_fall2", f2, m2.fall);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        n_sc  += int'(sc1);
        n_r1  += int'(r1);
        n_f1  += int'(f1);
        n_db1 += int'(db1);
        n_r2  += int'(r2);
    endtask

    task automatic clr();
        n_sc = 0; n_r1 = 0; n_f1 = 0; n_db1 = 0; n_r2 = 0;
    endtask

    task automatic hold(input logic v, input int n);
        button_in = v;
        repeat (n) tick();
    endtask

    // k counts edges from the first one that samples the current input; -1 means never reached
    task automatic measure(input logic tgt, output int lat1, output int lat2);
        lat1 = -1;
        lat2 = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (lat1 < 0 && db1 == tgt) lat1 = k;
            if (lat2 < 0 && db2 == tgt) lat2 = k;
        end
    endtask

    task automatic bounce_then_hold(output int lat1, output int lat2);
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
        button_in = 1'b1;
        measure(1'b1, lat1, lat2);
    endtask

    initial begin
        int l1, l2;
        clr();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // idle low
        hold(1'b0, 50);
        chk("idle_change_count", n_sc, 0);
        chk("idle_db", db1, 0);
        chk("idle_rise_count", n_r1, 0);
        chk("idle_db2", db2, 0);
        // bounce then settle high
        clr();
        bounce_then_hold(l1, l2);
        chk("bounce_change_count", n_sc, 5);
        chk("bounce_lat16", l1, 18);
        chk("bounce_lat2", l2, 4);
        chk("bounce_rise_count", n_r1, 1);
        hold(1'b1, 60);
        // release
        clr();
        button_in = 1'b0;
        measure(1'b0, l1, l2);
        chk("drop_lat16", l1, 18);
        chk("drop_lat2", l2, 4);
        chk("drop_fall_count", n_f1, 1);
        chk("drop_rise_count", n_r1, 0);
        hold(1'b0, 10);
        clr();
        bounce_then_hold(l1, l2);
        chk("rebounce_lat16", l1, 18);
        chk("rebounce_rise_count", n_r1, 1);
        hold(1'b0, 40);
        // glitch length boundary for the default build
        clr();
        hold(1'b1, 16);
        hold(1'b0, 40);
        chk("glitch16_db_high_cycles", n_db1, 0);
        chk("glitch16_rise_count", n_r1, 0);
        chk("glitch16_fall_count", n_f1, 0);
        clr();
        hold(1'b1, 17);
        hold(1'b0, 40);
        chk("pulse17_rise_count", n_r1, 1);
        chk("pulse17_fall_count", n_f1, 1);
        // reset in the middle of qualification (counter at 10 after edge 12)
        button_in = 1'b1;
        repeat (13) tick();
        reset = 1'b1;
        tick();
        chk("midreset_sync", ss1, 0);
        chk("midreset_db", db1, 0);
        chk("midreset_change", sc1, 0);
        reset = 1'b0;
        measure(1'b1, l1, l2);
        chk("postreset_lat16", l1, 18);
        chk("postreset_lat2", l2, 4);
        hold(1'b0, 40);
        // glitch length boundary for the short build
        clr();
        hold(1'b1, 2);
        hold(1'b0, 10);
        chk("pulse2_rise_count_s2", n_r2, 0);
        clr();
        hold(1'b1, 3);
        hold(1'b0, 10);
        chk("pulse3_rise_count_s2", n_r2, 1);
        // random levels with random hold times around both thresholds
        for (int i = 0; i < 200; i++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
